// File: rtl/sw_debounce_pkg.sv
// Shared constants, channel state encoding and counter sizing for the
// switch debouncer.
package sw_debounce_pkg;

    localparam int DEF_WIDTH        = 10;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 10;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_t;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioner signal bundle: raw pins and bypass in, clean levels,
// change pulses and the sample strobe out.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] raw_in;
    logic             bypass;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] change_pulse;
    logic             tick;

    modport master (
        output raw_in, bypass,
        input  clean_out, change_pulse, tick
    );

    modport slave (
        input  raw_in, bypass,
        output clean_out, change_pulse, tick
    );
endinterface

// File: rtl/sw_debounce_ch.sv
// One debounce channel: two-flop synchroniser, STABLE/PENDING FSM, tick
// counter, and the registered clean level and change pulse.
//   state      | meaning
//   ST_STABLE  | sync2 matches the clean level, counter parked at 0
//   ST_PENDING | sync2 differs, counting ticks toward a commit
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_clean,
    output logic o_pulse
);
    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_clean;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;
    ch_state_t     r_state;

    logic          w_clean_nxt;
    logic          w_pulse_nxt;
    logic [CW-1:0] w_cnt_nxt;
    ch_state_t     w_state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_BIT;
            r_sync2 <= RESET_BIT;
            r_clean <= RESET_BIT;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_STABLE;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_clean <= w_clean_nxt;
            r_pulse <= w_pulse_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_clean_nxt = r_clean;
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (i_bypass) begin
            w_clean_nxt = r_sync2;
            w_pulse_nxt = r_sync2 ^ r_clean;
        end else begin
            case (r_state)
                ST_STABLE: begin
                    w_cnt_nxt = '0;
                end
                ST_PENDING: begin
                    if (!i_tick) begin
                        w_cnt_nxt = r_cnt;
                    end else if (r_cnt == CNT_LAST) begin
                        w_clean_nxt = r_sync2;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            endcase
        end
        // State always mirrors (sync2 != clean) for the coming cycle, so a
        // bounce back to the clean level drops to STABLE regardless of tick.
        w_state_nxt = (r_sync1 != w_clean_nxt) ? ST_PENDING : ST_STABLE;
    end

    assign o_clean = r_clean;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch conditioner: shared sample-tick prescaler plus one
// independent debounce channel per switch bit.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
    input  logic         clk,
    input  logic         reset_n,
    sw_debounce_if.slave bus
);
    localparam int            PW         = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic [WIDTH-1:0] w_clean;
    logic [WIDTH-1:0] w_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == PRESC_LAST);
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        sw_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_BIT    (RESET_VAL[g])
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (bus.raw_in[g]),
            .i_tick   (r_tick),
            .i_bypass (bus.bypass),
            .o_clean  (w_clean[g]),
            .o_pulse  (w_pulse[g])
        );
    end

    assign bus.clean_out    = w_clean;
    assign bus.change_pulse = w_pulse;
    assign bus.tick         = r_tick;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and randomized checks of sw_debounce against a tick-counting
// reference model plus explicit latency bounds.
module tb_sw_debounce;
    localparam int W  = 10;
    localparam int TD = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .RESET_VAL    ({W{1'b0}})
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw history for the 2-cycle synchroniser, accepted
    // level, and the number of sample ticks seen since each bit diverged.
    logic [W-1:0] m_s1, m_s2, m_clean, m_pulse;
    logic         m_tick;
    int           m_edges;
    int           m_ticks_seen [W];
    int           pc [W];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_pulse = '0;
        m_tick = 1'b0; m_edges = 0;
        for (int i = 0; i < W; i++) m_ticks_seen[i] = 0;
    endtask

    task automatic clear_pc();
        for (int i = 0; i < W; i++) pc[i] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nc, np;
        nc = m_clean;
        np = '0;
        for (int i = 0; i < W; i++) begin
            if (bus.bypass) begin
                nc[i] = m_s2[i];
                np[i] = m_s2[i] ^ m_clean[i];
                m_ticks_seen[i] = 0;
            end else if (m_s2[i] == m_clean[i]) begin
                m_ticks_seen[i] = 0;
            end else if (m_tick) begin
                m_ticks_seen[i] = m_ticks_seen[i] + 1;
                if (m_ticks_seen[i] == ST) begin
                    nc[i] = m_s2[i];
                    np[i] = 1'b1;
                    m_ticks_seen[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = bus.raw_in;
        m_clean = nc;
        m_pulse = np;
        m_edges++;
        m_tick = (m_edges >= TD) && (m_edges % TD == 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("clean_out", bus.clean_out, m_clean);
        chk("change_pulse", bus.change_pulse, m_pulse);
        chk("tick", W'(bus.tick), W'(m_tick));
        for (int i = 0; i < W; i++) if (bus.change_pulse[i]) pc[i]++;
    endtask

    task automatic wait_change(input int b, input int budget, output int lat);
        logic old;
        old = bus.clean_out[b];
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (bus.clean_out[b] !== old) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, first_set, t_prev, t_last, guard;
        logic [W-1:0] ones, mask;

        bus.raw_in = {W{1'b1}};
        bus.bypass = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_clean", bus.clean_out, '0);
        chk("reset_pulse", bus.change_pulse, '0);
        chk("reset_tick", W'(bus.tick), '0);
        reset_n = 1'b1;
        clear_pc();

        // All bits held high through reset release.
        first_set = 0; t_prev = 0; t_last = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (first_set == 0 && bus.clean_out != '0) first_set = k;
            if (bus.tick) begin t_prev = t_last; t_last = k; end
        end
        chk_rng("t1_commit_latency", first_set, 11, 14);
        chk("t1_clean_all", bus.clean_out, {W{1'b1}});
        for (int i = 0; i < W; i++) ones[i] = (pc[i] == 1);
        chk("t1_one_pulse_per_bit", ones, {W{1'b1}});
        chk_rng("t1_tick_period", t_last - t_prev, TD, TD);

        // Clean rising step on bit 0.
        bus.raw_in = '0;
        repeat (20) step();
        chk("t2_settled", bus.clean_out, '0);
        bus.raw_in[0] = 1'b1;
        wait_change(0, 30, lat);
        chk_rng("t2_latency", lat, 11, 14);
        chk_rng("t2_pulse_coincident", int'(bus.change_pulse[0]), 1, 1);
        step();
        chk_rng("t2_pulse_one_cycle", int'(bus.change_pulse[0]), 0, 0);

        // Bounce on bit 3, then stable high.
        clear_pc();
        bus.raw_in[3] = 1'b1; repeat (5) step();
        bus.raw_in[3] = 1'b0; repeat (5) step();
        bus.raw_in[3] = 1'b1;
        wait_change(3, 30, lat);
        chk_rng("t3_latency_after_last_edge", lat, 1, 14);
        repeat (20) step();
        chk_rng("t3_single_pulse", pc[3], 1, 1);

        // Short glitch on bit 5.
        clear_pc();
        bus.raw_in[5] = 1'b1; repeat (6) step();
        bus.raw_in[5] = 1'b0; repeat (25) step();
        chk_rng("t4_no_pulse", pc[5], 0, 0);
        chk_rng("t4_clean_low", int'(bus.clean_out[5]), 0, 0);

        // Bypass tracking with 3-cycle latency.
        bus.bypass = 1'b1;
        bus.raw_in = 10'h155;
        repeat (3) step();
        chk("t5_track_155", bus.clean_out, 10'h155);
        bus.raw_in = 10'h2AA;
        repeat (2) step();
        chk("t5_not_yet", bus.clean_out, 10'h155);
        step();
        chk("t5_track_2aa", bus.clean_out, 10'h2AA);
        chk("t5_all_pulse", bus.change_pulse, {W{1'b1}});
        step();
        chk("t5_pulse_clear", bus.change_pulse, '0);
        bus.bypass = 1'b0;
        repeat (20) step();
        chk("t5_resume_stable", bus.clean_out, 10'h2AA);

        // Reset while bit 7 is pending with two ticks counted.
        bus.raw_in = '0;
        repeat (20) step();
        bus.raw_in[7] = 1'b1;
        guard = 0;
        while (m_ticks_seen[7] != 2 && guard < 20) begin
            step();
            guard++;
        end
        chk_rng("t6_reached_pending", m_ticks_seen[7], 2, 2);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_clean", bus.clean_out, '0);
        chk("t6_reset_pulse", bus.change_pulse, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_change(7, 30, lat);
        chk_rng("t6_restart_latency", lat, 11, 14);

        // Random toggles and occasional bypass windows.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                mask = '0;
                mask[$urandom_range(0, W-1)] = 1'b1;
                bus.raw_in = bus.raw_in ^ mask;
            end
            if ($urandom_range(0, 99) == 0) bus.bypass = ~bus.bypass;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
